filter_bank_buffer: RTL

FILTER_BANK_BUFFER -- requirements
Module: filter_bank_buffer

---
 rtl/filter_bank_buffer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/filter_bank_buffer.sv
// Filter/bias coefficient store: FSM-driven filter and bias loads, independent 1-cycle registered reads.
// Optional sticky bounds-error output err when FILTER_BUF_BOUNDS_CHECK_EN is defined.
module filter_bank_buffer #(
  parameter int DATA_W     = 16,
  parameter int K          = 5,
  parameter int DEPTH      = 1920,
  parameter int BIAS_DEPTH = 120
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld_start,
  input  logic                     ld_sel,
  input  logic [15:0]              ld_idx,
  input  logic                     wr_valid,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_last,
  output logic                     wr_ready,
  output logic                     busy,
  output logic                     ld_done,
  input  logic                     rd_req,
  input  logic [15:0]              rd_idx,
  input  logic [15:0]              rd_bidx,
  output logic                     rd_valid,
  output logic [K*K*DATA_W-1:0]    rd_filter,
  output logic [DATA_W-1:0]        rd_bias
`ifdef FILTER_BUF_BOUNDS_CHECK_EN
  ,output logic                    err
`endif
);

  localparam int NE    = K * K;
  localparam int FW    = NE * DATA_W;
  localparam int CNT_W = $clog2(NE + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BAW   = (BIAS_DEPTH > 1) ? $clog2(BIAS_DEPTH) : 1;
  localparam logic [16:0] DEPTH_L  = 17'(DEPTH);
  localparam logic [16:0] BDEPTH_L = 17'(BIAS_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD_FILT, LOAD_BIAS, DONE} state_t;

  logic [FW-1:0]     filt_mem [DEPTH];
  logic [DATA_W-1:0] bias_mem [BIAS_DEPTH];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FW-1:0]     stage_q, stage_d;
  logic [15:0]       idx_q, idx_d;
  logic [16:0]       baddr_q, baddr_d;
  logic              wr_ready_q, wr_ready_d;
  logic              busy_q, busy_d;
  logic              ld_done_q, ld_done_d;
  logic              rd_valid_q, rd_valid_d;
  logic [FW-1:0]     rd_filter_q, rd_filter_d;
  logic [DATA_W-1:0] rd_bias_q, rd_bias_d;

  logic xfer, filt_we, bias_we;
  logic filt_idx_ok, baddr_ok, rd_idx_ok, rd_bidx_ok;

  assign xfer        = wr_valid && wr_ready_q;
  assign filt_idx_ok = {1'b0, idx_q} < DEPTH_L;
  assign baddr_ok    = baddr_q < BDEPTH_L;
  assign rd_idx_ok   = {1'b0, rd_idx} < DEPTH_L;
  assign rd_bidx_ok  = {1'b0, rd_bidx} < BDEPTH_L;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    idx_d   = idx_q;
    baddr_d = baddr_q;
    filt_we = 1'b0;
    bias_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_start) begin
          idx_d   = ld_idx;
          baddr_d = {1'b0, ld_idx};
          cnt_d   = '0;
          state_d = ld_sel ? LOAD_FILT : LOAD_BIAS;
        end
      end
      LOAD_FILT: begin
        if (xfer) begin
          stage_d[cnt_q*DATA_W +: DATA_W] = wr_data;
          if (cnt_q == CNT_W'(NE - 1)) begin
            // Commit includes the beat arriving on this edge.
            filt_we = filt_idx_ok && rst_n;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      LOAD_BIAS: begin
        if (xfer) begin
          bias_we = baddr_ok && rst_n;
          // Saturate so a run past the top never wraps back into range.
          baddr_d = (&baddr_q) ? baddr_q : baddr_q + 17'd1;
          if (wr_last) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    wr_ready_d = (state_d == LOAD_FILT) || (state_d == LOAD_BIAS);
    busy_d     = (state_d != IDLE);
    ld_done_d  = (state_d == DONE);
  end

  always_comb begin
    rd_valid_d  = rd_req;
    rd_filter_d = rd_filter_q;
    rd_bias_d   = rd_bias_q;
    if (rd_req) begin
      rd_filter_d = rd_idx_ok  ? filt_mem[rd_idx[AW-1:0]]   : '0;
      rd_bias_d   = rd_bidx_ok ? bias_mem[rd_bidx[BAW-1:0]] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stage_q     <= '0;
      idx_q       <= '0;
      baddr_q     <= '0;
      wr_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      ld_done_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_filter_q <= '0;
      rd_bias_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stage_q     <= stage_d;
      idx_q       <= idx_d;
      baddr_q     <= baddr_d;
      wr_ready_q  <= wr_ready_d;
      busy_q      <= busy_d;
      ld_done_q   <= ld_done_d;
      rd_valid_q  <= rd_valid_d;
      rd_filter_q <= rd_filter_d;
      rd_bias_q   <= rd_bias_d;
    end
  end

  // Storage is deliberately left out of reset so committed contents survive it.
  always_ff @(posedge clk) begin
    if (filt_we) filt_mem[idx_q[AW-1:0]] <= stage_d;
    if (bias_we) bias_mem[baddr_q[BAW-1:0]] <= wr_data;
  end

  assign wr_ready  = wr_ready_q;
  assign busy      = busy_q;
  assign ld_done   = ld_done_q;
  assign rd_valid  = rd_valid_q;
  assign rd_filter = rd_filter_q;
  assign rd_bias   = rd_bias_q;

`ifdef FILTER_BUF_BOUNDS_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && ld_start && ld_sel && !({1'b0, ld_idx} < DEPTH_L)) err_d = 1'b1;
    if (state_q == LOAD_BIAS && xfer && !baddr_ok) err_d = 1'b1;
    if (rd_req && (!rd_idx_ok || !rd_bidx_ok)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule
